// File: rtl/regfile_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scan_reader
//  Description : Walks every address of a register-file read port in order,
//                captures each word and shows one selectable byte on the
//                board LEDs. Advances on a dwell timer (auto mode) or on a
//                debounced push-button step (manual mode).
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scan_reader #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int DWELL    = 50_000_000,
  parameter int DEBOUNCE = 1_000_000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode_Auto,
  input  logic              Step_Btn,
  input  logic [1:0]        Byte_Sel,
  output logic [ADDR_W-1:0] R_Addr,
  input  logic [DATA_W-1:0] R_Data,
  output logic [7:0]        LED,
  output logic [ADDR_W-1:0] Cur_Addr,
  output logic              Busy,
  output logic              Done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_dwell_w = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int c_deb_w   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(DWELL - 1);
  localparam logic [c_dwell_w-1:0] c_dwell_one  = c_dwell_w'(1);
  localparam logic [c_deb_w-1:0]   c_deb_last   = c_deb_w'(DEBOUNCE - 1);
  localparam logic [c_deb_w-1:0]   c_deb_one    = c_deb_w'(1);
  localparam logic [ADDR_W-1:0]    c_addr_last  = '1;
  localparam logic [ADDR_W-1:0]    c_addr_one   = ADDR_W'(1);

  // Scan state encoding
  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_setup = 3'd1;
  localparam logic [2:0] c_st_latch = 3'd2;
  localparam logic [2:0] c_st_show  = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0]           state_q, state_d;
  logic [ADDR_W-1:0]    raddr_q, raddr_d;
  logic [ADDR_W-1:0]    cur_q, cur_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [c_dwell_w-1:0] dwell_q, dwell_d;

  logic                 sync1_q, sync2_q;
  logic                 deb_q, deb_prev_q;
  logic [c_deb_w-1:0]   deb_cnt_q;
  logic                 start_prev_q;

  logic                 w_start_edge;
  logic                 w_step;
  logic                 w_advance;
  logic                 w_at_last;

  // --------------------------------------------------------------------------
  // Event detection
  // --------------------------------------------------------------------------
  // Start edge uses the previous-cycle level; the edge is consumed whatever
  // state sees it, so a Start while busy is simply lost.
  assign w_start_edge = Start & ~start_prev_q;

  // One-cycle pulse on each rising edge of the debounced button level.
  assign w_step = deb_q & ~deb_prev_q;

  // The scan leaves SHOW either on dwell expiry (auto) or on a step (manual).
  // Mode_Auto is looked at every SHOW cycle, so a mode change takes effect
  // immediately while the dwell count is preserved.
  assign w_advance = (state_q == c_st_show) &&
                     (Mode_Auto ? (dwell_q == c_dwell_last) : w_step);

  assign w_at_last = (raddr_q == c_addr_last);

  // Start edge flop, button synchroniser and debouncer.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      start_prev_q <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      deb_q        <= 1'b0;
      deb_prev_q   <= 1'b0;
      deb_cnt_q    <= '0;
    end else begin
      start_prev_q <= Start;
      sync1_q      <= Step_Btn;
      sync2_q      <= sync1_q;
      deb_prev_q   <= deb_q;
      // The debounced level follows only after DEBOUNCE consecutive cycles
      // of disagreement; any agreeing cycle restarts the count.
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == c_deb_last) begin
          deb_q     <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + c_deb_one;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scan state machine
  // --------------------------------------------------------------------------
  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (w_start_edge) state_d = c_st_setup;
      end
      c_st_setup: begin
        // One settle cycle for the combinational read path.
        state_d = c_st_latch;
      end
      c_st_latch: begin
        state_d = c_st_show;
      end
      c_st_show: begin
        if (w_advance) state_d = w_at_last ? c_st_done : c_st_setup;
      end
      c_st_done: begin
        if (w_start_edge) state_d = c_st_setup;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // State-decoded outputs and LED byte mux of the captured word.
  always_comb begin
    Busy     = (state_q == c_st_setup) || (state_q == c_st_latch) ||
               (state_q == c_st_show);
    Done     = (state_q == c_st_done);
    R_Addr   = raddr_q;
    Cur_Addr = cur_q;
    case (Byte_Sel)
      2'b00:   LED = data_q[7:0];
      2'b01:   LED = data_q[15:8];
      2'b10:   LED = data_q[23:16];
      default: LED = data_q[31:24];
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // Next values for read address, capture registers and dwell counter.
  always_comb begin
    raddr_d = raddr_q;
    cur_d   = cur_q;
    data_d  = data_q;
    dwell_d = dwell_q;
    case (state_q)
      c_st_idle, c_st_done: begin
        if (w_start_edge) raddr_d = '0;
      end
      c_st_latch: begin
        // R_Data is only ever sampled here.
        data_d  = R_Data;
        cur_d   = raddr_q;
        dwell_d = '0;
      end
      c_st_show: begin
        if (w_advance) begin
          // The address stops at the top; it never wraps within a scan.
          if (!w_at_last) raddr_d = raddr_q + c_addr_one;
        end else if (Mode_Auto) begin
          dwell_d = dwell_q + c_dwell_one;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      raddr_q <= '0;
      cur_q   <= '0;
      data_q  <= '0;
      dwell_q <= '0;
    end else begin
      raddr_q <= raddr_d;
      cur_q   <= cur_d;
      data_q  <= data_d;
      dwell_q <= dwell_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scan_reader
//  Description : Self-checking bench for regfile_scan_reader with a behavioural
//                register file and a timing model of the scan.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scan_reader;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int DWELL    = 4;
  localparam int DEBOUNCE = 3;
  localparam int NWORDS   = 1 << ADDR_W;
  localparam int WORD_CYC = DWELL + 2;
  localparam int SCAN_CYC = WORD_CYC * NWORDS;

  logic              Clk       = 1'b0;
  logic              Reset     = 1'b0;
  logic              Start     = 1'b0;
  logic              Mode_Auto = 1'b1;
  logic              Step_Btn  = 1'b0;
  logic [1:0]        Byte_Sel  = 2'b00;
  logic [ADDR_W-1:0] R_Addr;
  logic [DATA_W-1:0] R_Data;
  logic [7:0]        LED;
  logic [ADDR_W-1:0] Cur_Addr;
  logic              Busy;
  logic              Done;

  logic [31:0] regs [NWORDS];
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          m_cur        = 0;
  logic [31:0] m_word       = '0;

  regfile_scan_reader #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DWELL   (DWELL),
    .DEBOUNCE(DEBOUNCE)
  ) u_dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Mode_Auto(Mode_Auto),
    .Step_Btn (Step_Btn),
    .Byte_Sel (Byte_Sel),
    .R_Addr   (R_Addr),
    .R_Data   (R_Data),
    .LED      (LED),
    .Cur_Addr (Cur_Addr),
    .Busy     (Busy),
    .Done     (Done)
  );

  // Behavioural register file: combinational read.
  assign R_Data = regs[R_Addr];

  always #5 Clk = ~Clk;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] s);
    logic [31:0] sh;
    sh = w >> (8 * s);
    return sh[7:0];
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    #1;
    tests_run++; if (LED !== 8'h00) begin tests_failed++; $display("FAIL reset_led got %h expected 00", LED); end
    tests_run++; if (R_Addr !== '0) begin tests_failed++; $display("FAIL reset_raddr got %0d expected 0", R_Addr); end
    tests_run++; if (Cur_Addr !== '0) begin tests_failed++; $display("FAIL reset_cur got %0d expected 0", Cur_Addr); end
    tests_run++; if (Busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b expected 0", Busy); end
    tests_run++; if (Done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b expected 0", Done); end
    @(posedge Clk);
    @(negedge Clk);
    Start    = 1'b0;
    Step_Btn = 1'b0;
    Reset    = 1'b1;
    m_cur    = 0;
    m_word   = '0;
    for (int i = 0; i < 5; i++) begin
      tick;
      tests_run++; if (Busy !== 1'b0 || Done !== 1'b0) begin tests_failed++; $display("FAIL reset_idle busy/done got %b%b expected 00", Busy, Done); end
      tests_run++; if (LED !== 8'h00) begin tests_failed++; $display("FAIL reset_idle_led got %h expected 00", LED); end
    end
  endtask

  // Full auto scan checked every cycle against the timing rules:
  // Start edge at cycle k=1; word n is captured at edge WORD_CYC*n+3;
  // R_Addr steps at edge WORD_CYC*n+7; DONE entered at edge SCAN_CYC+1.
  task automatic test_auto_scan(input bit rand_data, input int glitch_addr,
                                input bit start_at_end, input int abort_addr);
    int          e_raddr, e_cur;
    logic        e_busy, e_done;
    logic [31:0] e_word;
    Mode_Auto = 1'b1;
    for (int n = 0; n < NWORDS; n++) begin
      if (!rand_data) regs[n] = 32'hA500_0000 + n;
      else if (n != 3) regs[n] = $urandom;
    end
    if (!rand_data) Byte_Sel = 2'b00;
    Start = 1'b0;
    tick;
    for (int k = 1; k <= SCAN_CYC + 8; k++) begin
      Start = (k == 1) ||
              (glitch_addr >= 0 && k == WORD_CYC * glitch_addr + 5) ||
              (start_at_end && k == SCAN_CYC + 1);
      if (rand_data) begin
        Byte_Sel = 2'($urandom_range(0, 3));
        Step_Btn = 1'($urandom_range(0, 1));
        if (k == WORD_CYC * 3 + 3) Byte_Sel = 2'b00;
      end
      tick;
      if (k <= SCAN_CYC) begin
        e_busy  = 1'b1;
        e_done  = 1'b0;
        e_raddr = (k - 1) / WORD_CYC;
        if (k >= 3) begin
          e_cur  = (k - 3) / WORD_CYC;
          e_word = regs[e_cur];
        end else begin
          e_cur  = m_cur;
          e_word = m_word;
        end
      end else begin
        e_busy  = 1'b0;
        e_done  = 1'b1;
        e_raddr = NWORDS - 1;
        e_cur   = NWORDS - 1;
        e_word  = regs[NWORDS - 1];
      end
      tests_run++; if (Busy !== e_busy) begin tests_failed++; $display("FAIL auto_busy k=%0d got %b expected %b", k, Busy, e_busy); end
      tests_run++; if (Done !== e_done) begin tests_failed++; $display("FAIL auto_done k=%0d got %b expected %b", k, Done, e_done); end
      tests_run++; if (R_Addr !== 5'(e_raddr)) begin tests_failed++; $display("FAIL auto_raddr k=%0d got %0d expected %0d", k, R_Addr, e_raddr); end
      tests_run++; if (Cur_Addr !== 5'(e_cur)) begin tests_failed++; $display("FAIL auto_cur k=%0d got %0d expected %0d", k, Cur_Addr, e_cur); end
      tests_run++; if (LED !== byte_of(e_word, Byte_Sel)) begin tests_failed++; $display("FAIL auto_led k=%0d got %h expected %h", k, LED, byte_of(e_word, Byte_Sel)); end
      if (rand_data && k == WORD_CYC * 3 + 3) begin
        tests_run++; if (LED !== 8'h22) begin tests_failed++; $display("FAIL rescan_addr3 got %h expected 22", LED); end
      end
      if (abort_addr >= 0 && k == WORD_CYC * abort_addr + 4) begin
        #1;
        Reset = 1'b0;
        #1;
        tests_run++; if (LED !== 8'h00) begin tests_failed++; $display("FAIL abort_led got %h expected 00", LED); end
        tests_run++; if (R_Addr !== '0) begin tests_failed++; $display("FAIL abort_raddr got %0d expected 0", R_Addr); end
        tests_run++; if (Cur_Addr !== '0) begin tests_failed++; $display("FAIL abort_cur got %0d expected 0", Cur_Addr); end
        tests_run++; if (Busy !== 1'b0 || Done !== 1'b0) begin tests_failed++; $display("FAIL abort_busy_done got %b%b expected 00", Busy, Done); end
        Start    = 1'b0;
        Step_Btn = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset  = 1'b1;
        m_cur  = 0;
        m_word = '0;
        for (int i = 0; i < 12; i++) begin
          tick;
          tests_run++; if (Busy !== 1'b0 || Done !== 1'b0 || Cur_Addr !== '0 || R_Addr !== '0) begin
            tests_failed++; $display("FAIL abort_idle busy=%b done=%b cur=%0d raddr=%0d expected 0 0 0 0", Busy, Done, Cur_Addr, R_Addr);
          end
        end
        return;
      end
    end
    Start    = 1'b0;
    Step_Btn = 1'b0;
    m_cur    = NWORDS - 1;
    m_word   = regs[NWORDS - 1];
  endtask

  // Manual stepping, byte select, and register rewrite while displayed.
  task automatic test_manual;
    logic [7:0] exp_b [4];
    int hold, gap;
    exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
    Mode_Auto = 1'b0;
    Byte_Sel  = 2'b00;
    Step_Btn  = 1'b0;
    regs[0]   = 32'h1234_5678;
    regs[3]   = 32'h0000_0011;
    Start = 1'b0;
    tick;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    tests_run++; if (Busy !== 1'b1 || Done !== 1'b0) begin tests_failed++; $display("FAIL restart busy/done got %b%b expected 10", Busy, Done); end
    repeat (7) tick;
    tests_run++; if (Cur_Addr !== '0 || R_Addr !== '0) begin tests_failed++; $display("FAIL manual_hold cur=%0d raddr=%0d expected 0 0", Cur_Addr, R_Addr); end
    for (int s = 0; s < 4; s++) begin
      Byte_Sel = 2'(s);
      #1;
      tests_run++; if (LED !== exp_b[s]) begin tests_failed++; $display("FAIL byte_sel%0d got %h expected %h", s, LED, exp_b[s]); end
      tests_run++; if (R_Addr !== '0) begin tests_failed++; $display("FAIL byte_sel_raddr got %0d expected 0", R_Addr); end
    end
    Byte_Sel = 2'b00;
    tick;
    // Bouncing press: 1-0-1 glitches then held high.
    Step_Btn = 1'b1; tick;
    Step_Btn = 1'b0; tick;
    Step_Btn = 1'b1;
    repeat (15) tick;
    tests_run++; if (Cur_Addr !== 5'd1 || R_Addr !== 5'd1) begin tests_failed++; $display("FAIL bounce_step cur=%0d raddr=%0d expected 1 1", Cur_Addr, R_Addr); end
    tests_run++; if (LED !== byte_of(regs[1], 2'b00)) begin tests_failed++; $display("FAIL bounce_led got %h expected %h", LED, byte_of(regs[1], 2'b00)); end
    for (int p = 2; p <= 3; p++) begin
      Step_Btn = 1'b0; repeat (8) tick;
      Step_Btn = 1'b1; repeat (10) tick;
      tests_run++; if (Cur_Addr !== 5'(p)) begin tests_failed++; $display("FAIL press_step got %0d expected %0d", Cur_Addr, p); end
    end
    Step_Btn = 1'b0;
    tests_run++; if (LED !== 8'h11) begin tests_failed++; $display("FAIL addr3_led got %h expected 11", LED); end
    regs[3] = 32'h0000_0022;
    repeat (8) tick;
    tests_run++; if (LED !== 8'h11 || Cur_Addr !== 5'd3) begin tests_failed++; $display("FAIL rewrite_hold led=%h cur=%0d expected 11 3", LED, Cur_Addr); end
    m_cur = 3;
    for (int i = 0; i < 5; i++) begin
      hold     = $urandom_range(9, 14);
      gap      = $urandom_range(6, 12);
      Byte_Sel = 2'($urandom_range(0, 3));
      Step_Btn = 1'b1; repeat (hold) tick;
      Step_Btn = 1'b0; repeat (gap) tick;
      m_cur++;
      tests_run++; if (Cur_Addr !== 5'(m_cur) || R_Addr !== 5'(m_cur)) begin tests_failed++; $display("FAIL rand_step cur=%0d raddr=%0d expected %0d", Cur_Addr, R_Addr, m_cur); end
      tests_run++; if (LED !== byte_of(regs[m_cur], Byte_Sel)) begin tests_failed++; $display("FAIL rand_step_led got %h expected %h", LED, byte_of(regs[m_cur], Byte_Sel)); end
      tests_run++; if (Busy !== 1'b1) begin tests_failed++; $display("FAIL rand_step_busy got %b expected 1", Busy); end
    end
    m_word = regs[m_cur];
  endtask

  task automatic test_back_to_back;
    test_auto_scan(1'b1, -1, 1'b0, -1);
    test_auto_scan(1'b1, -1, 1'b0, -1);
  endtask

  initial begin
    for (int n = 0; n < NWORDS; n++) regs[n] = '0;
    test_reset;
    test_auto_scan(1'b0, 7, 1'b1, -1);
    test_manual;
    test_reset;
    test_auto_scan(1'b1, -1, 1'b0, 10);
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_scan_reader.md
Name: regfile_scan_reader

Overview:
- Read-side counterpart to the switch-driven register-file write path.
- Drives one read port of the 32x32 register file and walks addresses 0..31 in order.
- Captures each word and shows one selectable byte on the 8 board LEDs.
- Advances automatically after a dwell time or on a debounced push-button step. Used for board-level dump and verification of register contents.

Parameters:
- ADDR_W, 5, register-file address width; the scan covers 0..2^ADDR_W-1.
- DATA_W, 32, register-file data width; must be 32.
- DWELL, 50_000_000, Clk cycles each word is shown in auto mode; minimum 1.
- DEBOUNCE, 1_000_000, Clk cycles Step_Btn must be stable before a change is accepted; minimum 1.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- Start  input  1  synchronous level; a rising edge begins a scan.
- Mode_Auto  input  1  1 = timed advance, 0 = advance on button step.
- Step_Btn  input  1  raw push button, asynchronous, active-high.
- Byte_Sel  input  2  selects the LED byte: 00 = [7:0], 01 = [15:8], 10 = [23:16], 11 = [31:24].
- R_Addr  output  ADDR_W  read address to the register-file read port.
- R_Data  input  DATA_W  combinational read data returned for R_Addr.
- LED  output  8  selected byte of the captured word.
- Cur_Addr  output  ADDR_W  address of the word currently captured and displayed.
- Busy  output  1  high while a scan is in progress.
- Done  output  1  high after address 2^ADDR_W-1 has been shown; cleared by the next Start.

Behaviour:
- Reset (asynchronous, Reset=0):
  - state=IDLE; R_Addr=0, Cur_Addr=0, capture register Data_Q=0, so LED=0.
  - Busy=0, Done=0.
  - Dwell counter, debounce counter, synchroniser flops and Start edge flop are all cleared.
- Reset asserted mid-scan aborts immediately with no completion. After release the block waits in IDLE for a new Start edge.
- Step_Btn path:
  - 2-flop synchroniser, then the debounce counter.
  - The debounced level changes only after the synchronised input has differed from it for DEBOUNCE consecutive cycles.
  - A 0->1 transition of the debounced level produces a one-cycle step pulse.
- Start: its rising edge is detected with a one-flop delay (Start=1 and previous Start=0).
- State machine: IDLE, SETUP, LATCH, SHOW, DONE.
  - IDLE: Busy=0. On a Start edge: R_Addr<=0, Busy<=1, Done<=0, go to SETUP.
  - SETUP: one cycle; R_Addr is held stable so R_Data settles. Go to LATCH.
  - LATCH: Data_Q<=R_Data, Cur_Addr<=R_Addr, dwell counter<=0. Go to SHOW.
  - SHOW, auto (Mode_Auto=1): the dwell counter increments each cycle. When it reaches DWELL-1, the block advances on that edge.
  - SHOW, manual (Mode_Auto=0): the block advances on the edge where the step pulse is 1.
  - Mode_Auto is sampled every SHOW cycle. Switching mode mid-dwell leaves the counter value held, not cleared.
  - Advance: if R_Addr = 2^ADDR_W-1, go to DONE with Busy<=0 and Done<=1. Otherwise R_Addr<=R_Addr+1 and go to SETUP. R_Addr never wraps inside a scan.
  - DONE: Data_Q and Cur_Addr hold the last word. A Start edge behaves exactly as from IDLE.
- Latency: R_Addr change -> Data_Q updated 2 edges later (SETUP then LATCH). Each word occupies DWELL+2 cycles in auto mode.
- LED is a combinational mux of registered Data_Q by Byte_Sel. Changing Byte_Sel updates LED in the same cycle with no rescan.
- Ignored events (no effect, not queued):
  - Step pulses in IDLE, SETUP, LATCH and DONE.
  - Step pulses in auto mode.
  - A Start edge while Busy=1.
- Start edge coincident with the advance from the last address: DONE is entered that edge. That Start edge is consumed and does not restart the scan.
- R_Data is never sampled outside LATCH. Register-file writes during SHOW are not reflected until that address is rescanned.

Test Plan:
1. Auto full scan (DWELL=4, DEBOUNCE=3, reg[n]=32'hA5000000+n, Byte_Sel=00) -> LED shows 00,01,...,1F, each held 4 SHOW cycles plus 2 (SETUP/LATCH); Done=1 and Busy=0 exactly 32*6+1 cycles after the Start edge; LED stays 1F.
2. Byte select in SHOW with Data_Q=32'h12345678 -> Byte_Sel 00/01/10/11 gives LED 78/56/34/12 in the same cycle; R_Addr unchanged.
3. Manual mode, Step_Btn bouncing 1-0-1 in 1-cycle glitches then held high 5 cycles -> exactly one advance (Cur_Addr 0->1); holding longer produces no further advance; release and press again gives Cur_Addr 2.
4. Start pulse while Busy=1 at Cur_Addr=7 -> ignored, scan continues to 8; a Start after Done=1 restarts at Cur_Addr=0 with Done dropping to 0.
5. Reset=0 asserted mid-SHOW at Cur_Addr=10 -> same cycle, with no clock edge: LED=00, R_Addr=0, Cur_Addr=0, Busy=0, Done=0; after release it stays IDLE until Start.
6. reg[3] rewritten from 32'h11 to 32'h22 while Cur_Addr=3 is displayed -> LED stays 11 until the next scan shows 22 at address 3.
